// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB chunk first.
// Results are offered on a valid/ready handshake and held until taken.
module serial_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             c_q, sub_q, co_q, ovf_q;
  logic [IW-1:0]    idx_q;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             c_next;
  logic             accept, last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        accept = in_valid;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        last = (idx_q == LAST);
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shifts stand in for variable part-selects; sum is cleared on accept, so
  // OR-ing the new chunk into place is equivalent to writing that slice.
  always_comb begin
    a_ch = CHUNK'(a_q >> (int'(idx_q) * CHUNK));
    b_ch = CHUNK'(b_q >> (int'(idx_q) * CHUNK));
    {c_next, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c_q};
    sum_d = sum_q | (WIDTH'(s_ch) << (int'(idx_q) * CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
      sub_q <= 1'b0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
      idx_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= sub ? ~b : b;
        c_q   <= carryin ^ sub;
        sub_q <= sub;
        sum_q <= '0;
        idx_q <= '0;
      end else if (state_q == RUN) begin
        sum_q <= sum_d;
        c_q   <= c_next;
        idx_q <= idx_q + 1'b1;
        if (last) begin
          co_q  <= sub_q ^ c_next;
          ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carryout  = co_q;
  assign overflow  = ovf_q;

endmodule
